cpu_sequencer: RTL and testbench

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_sequencer.sv | 153 +++++++++++++++
 tb/tb_cpu_sequencer.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// Multi-cycle CPU control sequencer: FETCH/DECODE/EXEC/MEM/WB with memory-ack and optional FPU stall.
// Optional feature macro: FPU_STALL_EN (ADDF/MULF wait in EXEC for fpu_done).
module cpu_sequencer (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] opc,
    input  logic       br_cond,
    input  logic       dm_ack,
    input  logic       fpu_done,
    output logic       ir_load,
    output logic       pc_en,
    output logic       pc_sel,
    output logic       dm_req,
    output logic       dm_we,
    output logic       rf_we,
    output logic [1:0] wb_sel,
    output logic       fpu_start,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [5:0] OP_NOP   = 6'd0;
    localparam logic [5:0] OP_STORE = 6'd3;
    localparam logic [5:0] OP_LOAD  = 6'd4;
    localparam logic [5:0] OP_MOVE  = 6'd5;
    localparam logic [5:0] OP_MOVEI = 6'd16;
    localparam logic [5:0] OP_JUMP  = 6'd21;
    localparam logic [5:0] OP_BRA   = 6'd22;
    localparam logic [5:0] OP_ADDF  = 6'd23;
    localparam logic [5:0] OP_MULF  = 6'd24;

    state_t     state_q;
    logic [5:0] opc_q;

    function automatic logic is_nop(input logic [5:0] op);
        return (op == OP_NOP) || (op > OP_MULF);
    endfunction

    function automatic logic is_fp(input logic [5:0] op);
        return (op == OP_ADDF) || (op == OP_MULF);
    endfunction

`ifdef FPU_STALL_EN
    // Set after the first EXEC cycle of an FP op so fpu_start pulses only once.
    logic fpu_wait;
`else
    logic unused_fpu_done;
    assign unused_fpu_done = fpu_done;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_FETCH;
            opc_q    <= '0;
`ifdef FPU_STALL_EN
            fpu_wait <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_FETCH: state_q <= S_DECODE;
                S_DECODE: begin
                    opc_q <= opc;
                    if (is_nop(opc) || opc == OP_JUMP || opc == OP_BRA)
                        state_q <= S_FETCH;
                    else if (opc == OP_LOAD || opc == OP_STORE)
                        state_q <= S_MEM;
                    else if (opc == OP_MOVE || opc == OP_MOVEI)
                        state_q <= S_WB;
                    else
                        state_q <= S_EXEC;
                end
                S_EXEC: begin
`ifdef FPU_STALL_EN
                    if (is_fp(opc_q) && !fpu_done) begin
                        fpu_wait <= 1'b1;
                    end else begin
                        fpu_wait <= 1'b0;
                        state_q  <= S_WB;
                    end
`else
                    state_q <= S_WB;
`endif
                end
                S_MEM: begin
                    if (dm_ack)
                        state_q <= (opc_q == OP_STORE) ? S_FETCH : S_WB;
                end
                S_WB:    state_q <= S_FETCH;
                default: state_q <= S_FETCH;
            endcase
        end
    end

    // Outputs depend on the current state and same-cycle inputs (opc, br_cond, dm_ack),
    // and are all forced low while reset is high.
    always_comb begin
        ir_load   = 1'b0;
        pc_en     = 1'b0;
        pc_sel    = 1'b0;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        rf_we     = 1'b0;
        wb_sel    = 2'b00;
        fpu_start = 1'b0;
        state     = 3'd0;
        if (!reset) begin
            state = state_q;
            case (opc_q)
                OP_MOVE:  wb_sel = 2'b01;
                OP_MOVEI: wb_sel = 2'b10;
                OP_LOAD:  wb_sel = 2'b11;
                default:  wb_sel = 2'b00;
            endcase
            case (state_q)
                S_FETCH: ir_load = 1'b1;
                S_DECODE: begin
                    if (is_nop(opc)) begin
                        pc_en = 1'b1;
                    end else if (opc == OP_JUMP) begin
                        pc_en  = 1'b1;
                        pc_sel = 1'b1;
                    end else if (opc == OP_BRA) begin
                        pc_en  = 1'b1;
                        pc_sel = br_cond;
                    end
                end
                S_EXEC: begin
`ifdef FPU_STALL_EN
                    fpu_start = is_fp(opc_q) && !fpu_wait;
`endif
                end
                S_MEM: begin
                    dm_req = 1'b1;
                    dm_we  = (opc_q == OP_STORE);
                    pc_en  = dm_ack && (opc_q == OP_STORE);
                end
                S_WB: begin
                    rf_we = 1'b1;
                    pc_en = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: one step per clock, expected output vectors queued and compared.
module tb_cpu_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opc = '0;
    logic       br_cond = 1'b0;
    logic       dm_ack = 1'b0;
    logic       fpu_done = 1'b0;
    logic       ir_load, pc_en, pc_sel, dm_req, dm_we, rf_we, fpu_start;
    logic [1:0] wb_sel;
    logic [2:0] state;

    logic [11:0] exp_q[$];
    int applied = 0;
    int miscompares = 0;

`ifdef FPU_STALL_EN
    localparam logic FP = 1'b1;
`else
    localparam logic FP = 1'b0;
`endif

    cpu_sequencer dut (
        .clock(clock), .reset(reset), .opc(opc), .br_cond(br_cond),
        .dm_ack(dm_ack), .fpu_done(fpu_done), .ir_load(ir_load), .pc_en(pc_en),
        .pc_sel(pc_sel), .dm_req(dm_req), .dm_we(dm_we), .rf_we(rf_we),
        .wb_sel(wb_sel), .fpu_start(fpu_start), .state(state)
    );

    always #5 clock = ~clock;

    // Vector layout: {state, ir_load, pc_en, pc_sel, dm_req, dm_we, rf_we, wb_sel, fpu_start}
    function automatic logic [11:0] ev(input logic [2:0] st, input logic ir, pe, ps, dr, dw, rw,
                                       input logic [1:0] wb, input logic fs);
        return {st, ir, pe, ps, dr, dw, rw, wb, fs};
    endfunction
    function automatic logic [11:0] e_f(input logic [1:0] wb);
        return ev(3'd0, 1, 0, 0, 0, 0, 0, wb, 0);
    endfunction
    function automatic logic [11:0] e_d(input logic [1:0] wb, input logic pe, ps);
        return ev(3'd1, 0, pe, ps, 0, 0, 0, wb, 0);
    endfunction
    function automatic logic [11:0] e_e(input logic [1:0] wb, input logic fs);
        return ev(3'd2, 0, 0, 0, 0, 0, 0, wb, fs);
    endfunction
    function automatic logic [11:0] e_m(input logic [1:0] wb, input logic we, pe);
        return ev(3'd3, 0, pe, 0, 1, we, 0, wb, 0);
    endfunction
    function automatic logic [11:0] e_w(input logic [1:0] wb);
        return ev(3'd4, 0, 1, 0, 0, 0, 1, wb, 0);
    endfunction

    // One clock cycle: drive this cycle's inputs after the edge, then check the outputs.
    task automatic step(input string tag, input logic [5:0] op, input logic br, ack, done, rst,
                        input logic [11:0] exp);
        logic [11:0] obs;
        logic [11:0] want;
        @(posedge clock);
        #2;
        opc = op; br_cond = br; dm_ack = ack; fpu_done = done; reset = rst;
        exp_q.push_back(exp);
        #2;
        obs  = {state, ir_load, pc_en, pc_sel, dm_req, dm_we, rf_we, wb_sel, fpu_start};
        want = exp_q.pop_front();
        applied++;
        assert (obs === want) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    initial begin
        step("rst_a", 6'd1, 1, 1, 1, 1, 12'h000);
        step("rst_b", 6'd4, 0, 1, 0, 1, 12'h000);

        // ADD: FETCH, DECODE, EXEC, WB
        step("add_f", 6'd0, 0, 0, 0, 0, e_f(2'b00));
        step("add_d", 6'd1, 0, 0, 0, 0, e_d(2'b00, 0, 0));
        step("add_e", 6'd0, 0, 0, 0, 0, e_e(2'b00, 0));
        step("add_w", 6'd0, 0, 0, 0, 0, e_w(2'b00));

        // LOAD with an ack during DECODE (ignored) and a 3-cycle late ack in MEM
        step("ld_f",  6'd0, 0, 0, 0, 0, e_f(2'b00));
        step("ld_d",  6'd4, 0, 1, 0, 0, e_d(2'b00, 0, 0));
        for (int i = 0; i < 3; i++)
            step("ld_mwait", 6'd0, 0, 0, 0, 0, e_m(2'b11, 0, 0));
        step("ld_mack", 6'd0, 0, 1, 0, 0, e_m(2'b11, 0, 0));
        step("ld_w",  6'd0, 0, 0, 0, 0, e_w(2'b11));

        // STORE with ack on the first MEM cycle
        step("st_f",  6'd0, 0, 0, 0, 0, e_f(2'b11));
        step("st_d",  6'd3, 0, 0, 0, 0, e_d(2'b11, 0, 0));
        step("st_m",  6'd0, 0, 1, 0, 0, e_m(2'b00, 1, 1));

        // Branches, undefined opcode, jump
        step("bra1_f", 6'd0, 0, 0, 0, 0, e_f(2'b00));
        step("bra1_d", 6'd22, 1, 0, 0, 0, e_d(2'b00, 1, 1));
        step("bra0_f", 6'd0, 0, 0, 0, 0, e_f(2'b00));
        step("bra0_d", 6'd22, 0, 0, 0, 0, e_d(2'b00, 1, 0));
        step("op63_f", 6'd0, 0, 0, 0, 0, e_f(2'b00));
        step("op63_d", 6'd63, 1, 0, 0, 0, e_d(2'b00, 1, 0));
        step("jmp_f",  6'd0, 0, 0, 0, 0, e_f(2'b00));
        step("jmp_d",  6'd21, 0, 0, 0, 0, e_d(2'b00, 1, 1));

        // MOVE / MOVEI go straight to writeback
        step("mov_f",  6'd0, 0, 0, 0, 0, e_f(2'b00));
        step("mov_d",  6'd5, 0, 0, 0, 0, e_d(2'b00, 0, 0));
        step("mov_w",  6'd0, 0, 0, 0, 0, e_w(2'b01));
        step("movi_f", 6'd0, 0, 0, 0, 0, e_f(2'b01));
        step("movi_d", 6'd16, 0, 0, 0, 0, e_d(2'b01, 0, 0));
        step("movi_w", 6'd0, 0, 0, 0, 0, e_w(2'b10));

        // MULF: stalls for fpu_done only when the FPU stall feature is built in
        step("mulf_f", 6'd0, 0, 0, 0, 0, e_f(2'b10));
        step("mulf_d", 6'd24, 0, 0, 0, 0, e_d(2'b10, 0, 0));
        step("mulf_e0", 6'd0, 0, 0, 0, 0, e_e(2'b00, FP));
        if (FP) begin
            for (int i = 0; i < 4; i++)
                step("mulf_ewait", 6'd0, 0, 0, 0, 0, e_e(2'b00, 0));
            step("mulf_edone", 6'd0, 0, 0, 1, 0, e_e(2'b00, 0));
        end
        step("mulf_w", 6'd0, 0, 0, 0, 0, e_w(2'b00));

        // ADDF with fpu_done in the same cycle as fpu_start
        step("addf_f", 6'd0, 0, 0, 0, 0, e_f(2'b00));
        step("addf_d", 6'd23, 0, 0, 0, 0, e_d(2'b00, 0, 0));
        step("addf_e", 6'd0, 0, 0, 1, 0, e_e(2'b00, FP));
        step("addf_w", 6'd0, 0, 0, 0, 0, e_w(2'b00));

        // Reset in the middle of a LOAD's MEM wait aborts it
        step("abrt_f",  6'd0, 0, 0, 0, 0, e_f(2'b00));
        step("abrt_d",  6'd4, 0, 0, 0, 0, e_d(2'b00, 0, 0));
        step("abrt_m",  6'd0, 0, 0, 0, 0, e_m(2'b11, 0, 0));
        step("abrt_rst", 6'd0, 0, 0, 0, 1, 12'h000);
        step("abrt_f2", 6'd0, 0, 1, 0, 0, e_f(2'b00));
        step("abrt_d2", 6'd0, 0, 0, 0, 0, e_d(2'b00, 1, 0));
        step("abrt_f3", 6'd0, 0, 0, 0, 0, e_f(2'b00));

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
